// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction and limit-mode encodings for chapter counters
package counter_pkg;

  // Direction encoding for up_down
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Limit-mode encoding for sat
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_ud_mod_if.sv
// rtl/counter_ud_mod_if.sv - control and status bundle for the up/down modulus counter
interface counter_ud_mod_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = WIDTH
);

  logic              en;
  logic              up_down;
  logic              sat;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  cnt;
  logic              at_max;
  logic              at_min;
  logic              wrap;
  logic              clamp;

  // Controller side: drives commands, observes count and events
  modport master (
    output en, up_down, sat, step, load, load_val,
    input  cnt, at_max, at_min, wrap, clamp
  );

  // Counter side
  modport slave (
    input  en, up_down, sat, step, load, load_val,
    output cnt, at_max, at_min, wrap, clamp
  );

endinterface

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next-count and limit-event calculation
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAX    = 2**WIDTH-1,
  parameter int STEP_W = WIDTH
) (
  input  logic [WIDTH-1:0]  cnt_i,
  input  logic              up_down_i,
  input  logic              sat_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDTH-1:0]  next_o,
  output logic              wrap_n_o,
  output logic              clamp_n_o
);

  // Two guard bits above the wider operand so cnt + step can never overflow
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 2;
  localparam logic [AW-1:0] MAX_A = AW'(MAX);
  localparam logic [AW-1:0] MOD_A = AW'(MAX + 1);

  logic [AW-1:0] c_a;
  logic [AW-1:0] s_a;
  logic [AW-1:0] t_up;
  logic [AW-1:0] t_up_mod;
  logic [AW-1:0] s_mod;
  logic [AW-1:0] t_dn_wrap;
  logic [AW-1:0] next_a;

  assign c_a       = AW'(cnt_i);
  assign s_a       = AW'(step_i);
  assign t_up      = c_a + s_a;
  assign t_up_mod  = t_up % MOD_A;
  // Steps of a full modulus or more reduce first, so step == MAX+1 lands back on cnt
  assign s_mod     = s_a % MOD_A;
  assign t_dn_wrap = (c_a + MOD_A - s_mod) % MOD_A;

  // Select next value and flag whether a limit was crossed (wrap) or hit (clamp)
  always_comb begin
    next_a    = c_a;
    wrap_n_o  = 1'b0;
    clamp_n_o = 1'b0;
    if (up_down_i == DIR_UP) begin
      if (t_up <= MAX_A) begin
        next_a = t_up;
      end else if (sat_i == MODE_SAT) begin
        next_a    = MAX_A;
        clamp_n_o = 1'b1;
      end else begin
        next_a   = t_up_mod;
        wrap_n_o = 1'b1;
      end
    end else begin
      if (s_a <= c_a) begin
        next_a = c_a - s_a;
      end else if (sat_i == MODE_SAT) begin
        next_a    = '0;
        clamp_n_o = 1'b1;
      end else begin
        next_a   = t_dn_wrap;
        wrap_n_o = 1'b1;
      end
    end
  end

  assign next_o = WIDTH'(next_a);

endmodule

// File: rtl/counter_ud_mod.sv
// rtl/counter_ud_mod.sv - up/down counter with modulus, step, load, wrap/saturate
module counter_ud_mod
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAX    = 2**WIDTH-1,
  parameter int STEP_W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  counter_ud_mod_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             clamp_q, clamp_d;

  logic [WIDTH-1:0] next_cnt;
  logic             next_wrap;
  logic             next_clamp;

  counter_next #(
    .WIDTH  (WIDTH),
    .MAX    (MAX),
    .STEP_W (STEP_W)
  ) u_next (
    .cnt_i     (cnt_q),
    .up_down_i (bus.up_down),
    .sat_i     (bus.sat),
    .step_i    (bus.step),
    .next_o    (next_cnt),
    .wrap_n_o  (next_wrap),
    .clamp_n_o (next_clamp)
  );

  // Load beats counting; event flags are one-shot so they default low every edge
  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    clamp_d = 1'b0;
    if (bus.load) begin
      if (bus.load_val > MAX_V) begin
        cnt_d   = MAX_V;
        clamp_d = 1'b1;
      end else begin
        cnt_d = bus.load_val;
      end
    end else if (bus.en && (bus.step != '0)) begin
      cnt_d   = next_cnt;
      wrap_d  = next_wrap;
      clamp_d = next_clamp;
    end
  end

  // Count and event registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      clamp_q <= clamp_d;
    end
  end

  assign bus.cnt    = cnt_q;
  assign bus.wrap   = wrap_q;
  assign bus.clamp  = clamp_q;
  assign bus.at_max = (cnt_q == MAX_V);
  assign bus.at_min = (cnt_q == '0);

endmodule

// File: tb/tb_counter_ud_mod.sv
// tb/tb_counter_ud_mod.sv - directed self-checking bench for counter_ud_mod
module tb_counter_ud_mod;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  counter_ud_mod_if #(.WIDTH(4), .STEP_W(4)) ifa ();
  counter_ud_mod_if #(.WIDTH(8), .STEP_W(9)) ifb ();

  counter_ud_mod #(.WIDTH(4), .MAX(9), .STEP_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  counter_ud_mod #(.WIDTH(8), .MAX(255), .STEP_W(9)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic ud, input logic sat, input logic [3:0] step,
                         input logic load, input logic [3:0] lv);
    ifa.en = en; ifa.up_down = ud; ifa.sat = sat; ifa.step = step;
    ifa.load = load; ifa.load_val = lv;
  endtask

  task automatic drive_b(input logic en, input logic ud, input logic sat, input logic [8:0] step,
                         input logic load, input logic [7:0] lv);
    ifb.en = en; ifb.up_down = ud; ifb.sat = sat; ifb.step = step;
    ifb.load = load; ifb.load_val = lv;
  endtask

  task automatic expect_a(input string tag, input int c, input bit w, input bit cl);
    check_eq({tag, " cnt"}, 32'(ifa.cnt), 32'(c));
    check_eq({tag, " wrap"}, 32'(ifa.wrap), 32'(w));
    check_eq({tag, " clamp"}, 32'(ifa.clamp), 32'(cl));
  endtask

  task automatic expect_b(input string tag, input int c, input bit w, input bit cl);
    check_eq({tag, " cnt"}, 32'(ifb.cnt), 32'(c));
    check_eq({tag, " wrap"}, 32'(ifb.wrap), 32'(w));
    check_eq({tag, " clamp"}, 32'(ifb.clamp), 32'(cl));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_b(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);

    // Reset state
    tick();
    expect_a("rst_a", 0, 1'b0, 1'b0);
    check_eq("rst_a at_min", 32'(ifa.at_min), 32'd1);
    check_eq("rst_a at_max", 32'(ifa.at_max), 32'd0);
    expect_b("rst_b", 0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // 1. Reset mid-count, between edges
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    tick();
    check_eq("t1 loaded", 32'(ifa.cnt), 32'd5);
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1 async cnt", 32'(ifa.cnt), 32'd0);
    check_eq("t1 async at_min", 32'(ifa.at_min), 32'd1);
    #1 rst_n = 1'b1;

    // 2. Up, wrap, step 3 from 0
    drive_a(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0);
    tick(); expect_a("t2 e1", 3, 1'b0, 1'b0);
    tick(); expect_a("t2 e2", 6, 1'b0, 1'b0);
    tick(); expect_a("t2 e3", 9, 1'b0, 1'b0);
    check_eq("t2 at_max", 32'(ifa.at_max), 32'd1);
    tick(); expect_a("t2 e4", 2, 1'b1, 1'b0);
    check_eq("t2 at_max after", 32'(ifa.at_max), 32'd0);

    // 3. Down, saturate, step 4 from 6
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd6);
    tick(); expect_a("t3 load", 6, 1'b0, 1'b0);
    drive_a(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0);
    tick(); expect_a("t3 e1", 2, 1'b0, 1'b0);
    tick(); expect_a("t3 e2", 0, 1'b0, 1'b1);
    check_eq("t3 at_min", 32'(ifa.at_min), 32'd1);
    tick(); expect_a("t3 e3", 0, 1'b0, 1'b1);

    // 4. Out-of-range load clamps and beats en/step
    drive_a(1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 4'd12);
    tick(); expect_a("t4 load12", 9, 1'b0, 1'b1);
    drive_a(1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 4'd4);
    tick(); expect_a("t4 load4", 4, 1'b0, 1'b0);

    // 5. Hold via en=0 or step=0 at 7
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7);
    tick();
    drive_a(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0);
    tick(); expect_a("t5 en0", 7, 1'b0, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); expect_a("t5 step0", 7, 1'b0, 1'b0);
    drive_a(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
    tick(); expect_a("t5 both", 7, 1'b0, 1'b0);

    // Extra wrap corners: step == M, step > M, down wrap, saturate at MAX
    drive_a(1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 4'd0);
    tick(); expect_a("x stepM", 7, 1'b1, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
    tick(); expect_a("x step15", 2, 1'b1, 1'b0);
    drive_a(1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0);
    tick(); expect_a("x down wrap", 7, 1'b1, 1'b0);
    drive_a(1'b1, 1'b1, 1'b0, 4'd13, 1'b0, 4'd0);
    tick(); expect_a("x down big", 4, 1'b1, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9);
    tick();
    drive_a(1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
    tick(); expect_a("x sat at max", 9, 1'b0, 1'b1);
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

    // 6. Default-size counter, STEP_W 9
    drive_b(1'b1, 1'b1, 1'b0, 9'd1, 1'b0, 8'd0);
    tick(); expect_b("t6 down", 255, 1'b1, 1'b0);
    check_eq("t6 at_max", 32'(ifb.at_max), 32'd1);
    drive_b(1'b1, 1'b0, 1'b0, 9'd10, 1'b0, 8'd0);
    tick(); expect_b("t6 up10", 9, 1'b1, 1'b0);
    drive_b(1'b1, 1'b0, 1'b0, 9'd256, 1'b0, 8'd0);
    tick(); expect_b("t6 step256", 9, 1'b1, 1'b0);
    drive_b(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);
    tick(); expect_b("t6 hold", 9, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
